// File: rtl/fpu_pkg.sv
// Shared binary32 field widths, opcode/constant definitions and small helpers
// used by the add/multiply datapaths and the round/pack stage.
package fpu_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int BIAS      = 127;
    localparam int SIG_W     = 27;   // hidden + 23 fraction + guard/round/sticky
    localparam int EXP_EXT_W = 12;   // signed working exponent

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp_eff;
        logic [MAN_W:0]   man;
        logic             nan;
        logic             inf;
        logic             zero;
    } fp_unpk_t;

    // Subnormals get hidden bit 0 and effective exponent 1
    function automatic fp_unpk_t fp_unpack(input logic [31:0] v);
        fp_unpk_t         u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e         = v[MAN_W+EXP_W-1:MAN_W];
        f         = v[MAN_W-1:0];
        u.sign    = v[31];
        u.exp_eff = (e == '0) ? 8'd1 : e;
        u.man     = {|e, f};
        u.nan     = (&e) & (|f);
        u.inf     = (&e) & ~(|f);
        u.zero    = ~(|v[30:0]);
        return u;
    endfunction

    function automatic logic [SIG_W-1:0] shr_sticky(input logic [SIG_W-1:0] v,
                                                     input logic [EXP_EXT_W-1:0] sh);
        logic [SIG_W-1:0] r;
        logic [SIG_W-1:0] mask;
        if (sh >= EXP_EXT_W'(SIG_W)) begin
            r = {{(SIG_W-1){1'b0}}, |v};
        end else begin
            mask = ~({SIG_W{1'b1}} << sh);
            r    = v >> sh;
            r[0] = r[0] | (|(v & mask));
        end
        return r;
    endfunction

endpackage

// File: rtl/fpu_round_pack.sv
// Round-to-nearest-even and pack of a normalized significand into binary32,
// including subnormal denormalization and overflow to infinity.
module fpu_round_pack
    import fpu_pkg::*;
(
    input  logic                        i_sign,
    input  logic signed [EXP_EXT_W-1:0] i_exp,
    input  logic [SIG_W-1:0]            i_sig,
    output logic [31:0]                 o_data
);

    logic [SIG_W-1:0]            w_sig_dn;
    logic signed [EXP_EXT_W-1:0] w_exp_dn;
    logic [EXP_EXT_W-1:0]        w_sh;
    logic [MAN_W+1:0]            w_man_rnd;
    logic signed [EXP_EXT_W-1:0] w_exp_rnd;
    logic [MAN_W-1:0]            w_frac;
    logic                        w_hidden;

    function automatic logic rne_up(input logic [SIG_W-1:0] sig);
        return sig[2] & (sig[1] | sig[0] | sig[3]);
    endfunction

    always_comb begin
        w_sig_dn  = i_sig;
        w_exp_dn  = i_exp;
        w_sh      = 12'd1 - EXP_EXT_W'(i_exp);
        w_frac    = '0;
        w_exp_rnd = '0;
        o_data    = '0;

        // Below the normal range: shift into subnormal position at exponent 1
        if (i_exp < 12'sd1) begin
            w_sig_dn = shr_sticky(i_sig, w_sh);
            w_exp_dn = 12'sd1;
        end

        w_man_rnd = {1'b0, w_sig_dn[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rne_up(w_sig_dn)};
        if (w_man_rnd[MAN_W+1]) begin
            w_frac    = w_man_rnd[MAN_W:1];
            w_exp_rnd = w_exp_dn + 12'sd1;
        end else begin
            w_frac    = w_man_rnd[MAN_W-1:0];
            w_exp_rnd = w_exp_dn;
        end
        w_hidden = w_man_rnd[MAN_W+1] | w_man_rnd[MAN_W];

        if (w_exp_rnd >= 12'sd255)
            o_data = {i_sign, POS_INF[30:0]};
        else if (!w_hidden)
            o_data = {i_sign, {EXP_W{1'b0}}, w_frac};
        else
            o_data = {i_sign, w_exp_rnd[EXP_W-1:0], w_frac};
    end

endmodule

// File: rtl/fpu_core.sv
// Single-precision add/multiply unit with one-cycle latency; both datapaths
// share one round/pack stage, specials override the rounded result.
module fpu_core
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INST_WIDTH = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    fp_unpk_t                    w_a;
    fp_unpk_t                    w_b;
    logic                        w_is_mul;

    logic                        w_a_big;
    logic                        w_big_s;
    logic [EXP_W-1:0]            w_big_e;
    logic [MAN_W:0]              w_big_m;
    logic [EXP_W-1:0]            w_sml_e;
    logic [MAN_W:0]              w_sml_m;
    logic [SIG_W-1:0]            w_sml_sig;
    logic [SIG_W:0]              w_sum;
    logic [4:0]                  w_add_lz;
    logic [SIG_W-1:0]            w_add_sig;
    logic signed [EXP_EXT_W-1:0] w_add_exp;
    logic                        w_add_sign;

    logic [2*MAN_W+1:0]          w_prod;
    logic [5:0]                  w_mul_lz;
    logic [2*MAN_W+1:0]          w_prod_n;
    logic [SIG_W-1:0]            w_mul_sig;
    logic signed [EXP_EXT_W-1:0] w_mul_exp;

    logic                        w_rp_sign;
    logic signed [EXP_EXT_W-1:0] w_rp_exp;
    logic [SIG_W-1:0]            w_rp_sig;
    logic [31:0]                 w_rp_data;
    logic [31:0]                 w_result;

    logic [DATA_WIDTH-1:0]       r_data_p1;
    logic                        r_vld_p1;

    function automatic logic [4:0] lzc27(input logic [SIG_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(SIG_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] lzc48(input logic [2*MAN_W+1:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd48;
        found = 1'b0;
        for (int i = 2*MAN_W + 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(2*MAN_W + 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign w_a      = fp_unpack(i_data_a);
    assign w_b      = fp_unpack(i_data_b);
    assign w_is_mul = (i_inst[0] == OP_MUL);

    // Add: larger magnitude first so effective subtraction never goes negative
    always_comb begin
        w_a_big   = (i_data_a[30:0] >= i_data_b[30:0]);
        w_big_s   = w_a_big ? w_a.sign    : w_b.sign;
        w_big_e   = w_a_big ? w_a.exp_eff : w_b.exp_eff;
        w_big_m   = w_a_big ? w_a.man     : w_b.man;
        w_sml_e   = w_a_big ? w_b.exp_eff : w_a.exp_eff;
        w_sml_m   = w_a_big ? w_b.man     : w_a.man;
        w_sml_sig = shr_sticky({w_sml_m, 3'b000}, {4'd0, w_big_e - w_sml_e});

        if (w_a.sign ^ w_b.sign)
            w_sum = {1'b0, w_big_m, 3'b000} - {1'b0, w_sml_sig};
        else
            w_sum = {1'b0, w_big_m, 3'b000} + {1'b0, w_sml_sig};

        w_add_lz = lzc27(w_sum[SIG_W-1:0]);
        if (w_sum[SIG_W]) begin
            w_add_sig = {w_sum[SIG_W:2], w_sum[1] | w_sum[0]};
            w_add_exp = $signed({4'd0, w_big_e}) + 12'sd1;
        end else begin
            w_add_sig = w_sum[SIG_W-1:0] << w_add_lz;
            w_add_exp = $signed({4'd0, w_big_e}) - $signed({7'd0, w_add_lz});
        end
        w_add_sign = (w_sum == '0) ? (w_a.sign & w_b.sign) : w_big_s;
    end

    // Multiply: product of 1.23 significands is 2.46; normalize by LZC
    always_comb begin
        w_prod    = w_a.man * w_b.man;
        w_mul_lz  = lzc48(w_prod);
        w_prod_n  = w_prod << w_mul_lz;
        w_mul_sig = {w_prod_n[2*MAN_W+1:22], |w_prod_n[21:0]};
        w_mul_exp = $signed({4'd0, w_a.exp_eff}) + $signed({4'd0, w_b.exp_eff})
                  - $signed(12'(BIAS - 1)) - $signed({6'd0, w_mul_lz});
    end

    assign w_rp_sign = w_is_mul ? (w_a.sign ^ w_b.sign) : w_add_sign;
    assign w_rp_exp  = w_is_mul ? w_mul_exp : w_add_exp;
    assign w_rp_sig  = w_is_mul ? w_mul_sig : w_add_sig;

    fpu_round_pack u_round_pack (
        .i_sign (w_rp_sign),
        .i_exp  (w_rp_exp),
        .i_sig  (w_rp_sig),
        .o_data (w_rp_data)
    );

    always_comb begin
        w_result = w_rp_data;
        if (w_a.nan || w_b.nan) begin
            w_result = QNAN;
        end else if (w_is_mul) begin
            if ((w_a.inf && w_b.zero) || (w_b.inf && w_a.zero))
                w_result = QNAN;
            else if (w_a.inf || w_b.inf)
                w_result = {w_a.sign ^ w_b.sign, POS_INF[30:0]};
        end else begin
            if (w_a.inf && w_b.inf && (w_a.sign ^ w_b.sign))
                w_result = QNAN;
            else if (w_a.inf)
                w_result = {w_a.sign, POS_INF[30:0]};
            else if (w_b.inf)
                w_result = {w_b.sign, POS_INF[30:0]};
        end
    end

    // Stage p1: result register, data held while idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= i_valid;
            if (i_valid)
                r_data_p1 <= w_result;
        end
    end

    assign o_data  = r_data_p1;
    assign o_valid = r_vld_p1;

endmodule

// File: tb/tb_fpu_core.sv
// Directed-vector bench for fpu_core: reset, single requests, back-to-back
// requests and reset during a valid cycle.
module tb_fpu_core;

    localparam int N_VEC = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [0:0]  inst;
    logic        valid;
    logic [31:0] out_data;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic        v_op  [N_VEC];
    logic [31:0] v_a   [N_VEC];
    logic [31:0] v_b   [N_VEC];
    logic [31:0] v_exp [N_VEC];

    fpu_core #(.DATA_WIDTH(32), .INST_WIDTH(1)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_data_a (data_a),
        .i_data_b (data_b),
        .i_inst   (inst),
        .i_valid  (valid),
        .o_data   (out_data),
        .o_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e);
        v_op[i]  = op;
        v_a[i]   = a;
        v_b[i]   = b;
        v_exp[i] = e;
    endtask

    task automatic drive(input int i);
        inst   = v_op[i];
        data_a = v_a[i];
        data_b = v_b[i];
        valid  = 1'b1;
    endtask

    task automatic idle_inputs();
        valid  = 1'b0;
        data_a = '0;
        data_b = '0;
        inst   = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // op 0 = add, 1 = mul
        set_vec(0,  1'b0, 32'h3F800000, 32'h40000000, 32'h40400000);
        set_vec(1,  1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000);
        set_vec(2,  1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000);
        set_vec(3,  1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002);
        set_vec(4,  1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000);
        set_vec(5,  1'b0, 32'h80000000, 32'h80000000, 32'h80000000);
        set_vec(6,  1'b1, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
        set_vec(7,  1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000);
        set_vec(8,  1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        set_vec(9,  1'b1, 32'h00800000, 32'h3F000000, 32'h00400000);
        set_vec(10, 1'b0, 32'h00000001, 32'h00000001, 32'h00000002);
        set_vec(11, 1'b0, 32'h40400000, 32'hBF800000, 32'h40000000);
        set_vec(12, 1'b1, 32'hC0000000, 32'h40400000, 32'hC0C00000);
        set_vec(13, 1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        set_vec(14, 1'b1, 32'h7F800000, 32'hC0000000, 32'hFF800000);
        set_vec(15, 1'b0, 32'h00000000, 32'h80000000, 32'h00000000);

        rst_n = 1'b0;
        idle_inputs();
        #2;
        check("reset valid", {31'd0, out_valid}, 32'd0);
        check("reset data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            @(negedge clk);
            drive(i);
            @(posedge clk);
            #1;
            idle_inputs();
            check($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d data", i), out_data, v_exp[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d idle valid", i), {31'd0, out_valid}, 32'd0);
            check($sformatf("vec%0d hold data", i), out_data, v_exp[i]);
        end

        @(negedge clk);
        drive(0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            check($sformatf("b2b%0d valid", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("b2b%0d data", k), out_data, v_exp[k]);
            if (k < 9) begin
                @(negedge clk);
                drive(k + 1);
            end
        end
        @(posedge clk);
        #1;
        check("b2b end valid", {31'd0, out_valid}, 32'd0);

        @(negedge clk);
        drive(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid valid", {31'd0, out_valid}, 32'd0);
        check("rst mid data", out_data, 32'd0);
        @(posedge clk);
        #1;
        check("rst edge valid", {31'd0, out_valid}, 32'd0);
        check("rst edge data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        check("post rst valid", {31'd0, out_valid}, 32'd0);

        @(negedge clk);
        drive(12);
        @(posedge clk);
        #1;
        idle_inputs();
        check("recover valid", {31'd0, out_valid}, 32'd1);
        check("recover data", out_data, v_exp[12]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
